// File: rtl/veripg_timer_bank.sv
// Bank of NUM_CH independent programmable down-count timers, each with an
// IDLE/RUN/DONE control FSM, tick-qualified counting, abort and auto-reload.
module veripg_timer_bank #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       abort,
    input  logic [NUM_CH-1:0]       reload,
    input  logic [NUM_CH*WIDTH-1:0] period,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic                    any_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state     [NUM_CH];
    state_t            state_nxt [NUM_CH];
    logic [WIDTH-1:0]  cnt_p0    [NUM_CH];
    logic [WIDTH-1:0]  cnt_nxt   [NUM_CH];
    logic [NUM_CH-1:0] done_nxt;

    // Decrement that clamps at zero so a count can never wrap.
    function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
        return (v == '0) ? '0 : v - WIDTH'(1);
    endfunction

    always_comb begin
        done_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt_p0[i];
            case (state[i])
                IDLE: begin
                    if (!abort[i] && start[i]) begin
                        cnt_nxt[i]   = period[i*WIDTH +: WIDTH];
                        state_nxt[i] = (period[i*WIDTH +: WIDTH] == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (abort[i]) begin
                        state_nxt[i] = IDLE;
                        cnt_nxt[i]   = '0;
                    end else if (cnt_p0[i] == '0) begin
                        // Zero in RUN cannot normally occur; treat it as expiry.
                        state_nxt[i] = DONE;
                    end else if (tick) begin
                        cnt_nxt[i] = sat_dec(cnt_p0[i]);
                        if (cnt_p0[i] == WIDTH'(1)) begin
                            state_nxt[i] = DONE;
                        end
                    end
                end
                DONE: begin
                    if (abort[i]) begin
                        state_nxt[i] = IDLE;
                    end else if (reload[i] || start[i]) begin
                        cnt_nxt[i]   = period[i*WIDTH +: WIDTH];
                        state_nxt[i] = (period[i*WIDTH +: WIDTH] == '0) ? DONE : RUN;
                    end else begin
                        state_nxt[i] = IDLE;
                    end
                end
                default: begin
                    state_nxt[i] = IDLE;
                    cnt_nxt[i]   = '0;
                end
            endcase
            done_nxt[i] = (state_nxt[i] == DONE);
        end
    end

    // Stage p0: state, count and the pre-decoded aggregate done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]  <= IDLE;
                cnt_p0[i] <= '0;
            end
            any_done <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]  <= state_nxt[i];
                cnt_p0[i] <= cnt_nxt[i];
            end
            any_done <= |done_nxt;
        end
    end

    always_comb begin
        count = '0;
        busy  = '0;
        done  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            count[i*WIDTH +: WIDTH] = cnt_p0[i];
            busy[i]                 = (state[i] == RUN);
            done[i]                 = (state[i] == DONE);
        end
    end

endmodule

// File: tb/tb_veripg_timer_bank.sv
// Scoreboard bench for veripg_timer_bank: stimulus queues per-cycle expected
// output values, a negedge monitor pops and compares them.
module tb_veripg_timer_bank;

    localparam int W = 16;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tick;
    logic [N-1:0]     start;
    logic [N-1:0]     abort;
    logic [N-1:0]     reload;
    logic [N*W-1:0]   period;
    logic [N*W-1:0]   count;
    logic [N-1:0]     busy;
    logic [N-1:0]     done;
    logic             any_done;

    veripg_timer_bank #(.WIDTH(W), .NUM_CH(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .start    (start),
        .abort    (abort),
        .reload   (reload),
        .period   (period),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .any_done (any_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 count, 1 busy, 2 done, 3 any_done
    typedef struct {
        int cyc;
        int ch;
        int kind;
        int val;
    } exp_t;

    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;
    string kname[4] = '{"count", "busy", "done", "any_done"};

    function automatic int actual(int ch, int kind);
        case (kind)
            0:       return int'(count[ch*W +: W]);
            1:       return int'(busy[ch]);
            2:       return int'(done[ch]);
            default: return int'(any_done);
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                checks = checks + 1;
                if (actual(q[i].ch, q[i].kind) != q[i].val) begin
                    errors = errors + 1;
                    $display("FAIL %s ch%0d cyc%0d actual %0d required %0d",
                             kname[q[i].kind], q[i].ch, cyc,
                             actual(q[i].ch, q[i].kind), q[i].val);
                end
                q.delete(i);
            end else if (q[i].cyc < cyc) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL stale_%s ch%0d cyc%0d actual unchecked required %0d",
                         kname[q[i].kind], q[i].ch, q[i].cyc, q[i].val);
                q.delete(i);
            end
        end
    end

    task automatic expect_at(int c, int ch, int kind, int val);
        exp_t e;
        e.cyc  = c;
        e.ch   = ch;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic expect_quiet(int c);
        for (int ch = 0; ch < N; ch++) begin
            expect_at(c, ch, 0, 0);
            expect_at(c, ch, 1, 0);
            expect_at(c, ch, 2, 0);
        end
        expect_at(c, 0, 3, 0);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int s;

    initial begin
        rst_n  = 1'b0;
        tick   = 1'b0;
        start  = '0;
        abort  = '0;
        reload = '0;
        period = '0;
        step(2);
        rst_n = 1'b1;

        // Reset state, stable for ten cycles
        for (int c = cyc; c <= cyc + 10; c++) expect_quiet(c);
        step(10);

        // ch0 period 5, continuous tick; period change mid-run must not matter
        s = cyc;
        period[0*W +: W] = 16'd5;
        tick     = 1'b1;
        start[0] = 1'b1;
        expect_at(s, 0, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            expect_at(s + k, 0, 0, 6 - k);
            expect_at(s + k, 0, 1, 1);
            expect_at(s + k, 0, 2, 0);
            expect_at(s + k, 0, 3, 0);
        end
        expect_at(s + 6, 0, 0, 0);
        expect_at(s + 6, 0, 1, 0);
        expect_at(s + 6, 0, 2, 1);
        expect_at(s + 6, 0, 3, 1);
        expect_at(s + 7, 0, 1, 0);
        expect_at(s + 7, 0, 2, 0);
        expect_at(s + 7, 0, 3, 0);
        step(1);
        start[0] = 1'b0;
        step(1);
        period[0*W +: W] = 16'd2;
        step(6);

        // ch1 period 3 with auto-reload
        s = cyc;
        period[1*W +: W] = 16'd3;
        start[1]  = 1'b1;
        reload[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            expect_at(s + k, 1, 2, (k % 4 == 0) ? 1 : 0);
            expect_at(s + k, 1, 1, (k % 4 == 0) ? 0 : 1);
            expect_at(s + k, 0, 3, (k % 4 == 0) ? 1 : 0);
        end
        expect_at(s + 13, 1, 1, 0);
        expect_at(s + 13, 1, 2, 0);
        expect_at(s + 14, 1, 1, 0);
        step(1);
        start[1] = 1'b0;
        step(11);
        reload[1] = 1'b0;
        step(3);

        // ch2 period 10, tick one cycle in four
        s = cyc;
        period[2*W +: W] = 16'd10;
        tick     = 1'b0;
        start[2] = 1'b1;
        expect_at(s + 1, 2, 0, 10);
        for (int k = 2; k <= 37; k++) expect_at(s + k, 2, 0, 9 - (k - 2) / 4);
        for (int k = 1; k <= 37; k++) begin
            expect_at(s + k, 2, 1, 1);
            expect_at(s + k, 2, 2, 0);
        end
        expect_at(s + 38, 2, 0, 0);
        expect_at(s + 38, 2, 1, 0);
        expect_at(s + 38, 2, 2, 1);
        expect_at(s + 38, 0, 3, 1);
        expect_at(s + 39, 2, 2, 0);
        expect_at(s + 39, 0, 3, 0);
        for (int k = 1; k <= 40; k++) begin
            step(1);
            start[2] = 1'b0;
            tick = (k % 4 == 1);
        end

        // ch3 aborted at count 4 together with tick; ch0 runs alongside
        s = cyc;
        tick = 1'b1;
        period[0*W +: W] = 16'd6;
        period[3*W +: W] = 16'd8;
        start[0] = 1'b1;
        start[3] = 1'b1;
        for (int k = 1; k <= 5; k++) expect_at(s + k, 3, 0, 9 - k);
        for (int k = 6; k <= 8; k++) begin
            expect_at(s + k, 3, 0, 0);
            expect_at(s + k, 3, 1, 0);
        end
        for (int k = 0; k <= 9; k++) expect_at(s + k, 3, 2, 0);
        for (int k = 1; k <= 6; k++) begin
            expect_at(s + k, 0, 0, 7 - k);
            expect_at(s + k, 0, 1, 1);
        end
        expect_at(s + 7, 0, 2, 1);
        expect_at(s + 7, 0, 3, 1);
        expect_at(s + 8, 0, 2, 0);
        step(1);
        start = '0;
        step(4);
        abort[3] = 1'b1;
        step(1);
        abort[3] = 1'b0;
        step(5);

        // Zero period: straight to DONE, never busy
        s = cyc;
        period[2*W +: W] = 16'd0;
        start[2] = 1'b1;
        expect_at(s + 1, 2, 0, 0);
        expect_at(s + 1, 2, 1, 0);
        expect_at(s + 1, 2, 2, 1);
        expect_at(s + 1, 0, 3, 1);
        expect_at(s + 2, 2, 1, 0);
        expect_at(s + 2, 2, 2, 0);
        expect_at(s + 2, 0, 3, 0);
        step(1);
        start[2] = 1'b0;
        step(2);

        // Asynchronous reset while ch0 holds count 7
        s = cyc;
        period[0*W +: W] = 16'd9;
        start[0] = 1'b1;
        expect_at(s + 1, 0, 0, 9);
        expect_at(s + 2, 0, 0, 8);
        expect_at(s + 2, 0, 1, 1);
        for (int c = s + 3; c <= s + 15; c++) expect_quiet(c);
        step(1);
        start[0] = 1'b0;
        step(2);
        #2;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(12);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
